// File: rtl/ifetch_unit.sv
// Instruction fetch / next-PC stage: fetches via req/ack, issues to decode, selects next PC on retire.
// Latency: min 2 cycles per instruction (ack in first FETCH cycle, accept in first ISSUE cycle).
// Backpressure: waits indefinitely for imem_ack in FETCH and for instr_accept in ISSUE.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        branch,
  input  logic        jump,
  input  logic        jumpreg,
  input  logic        jumplink,
  input  logic        zero,
  input  logic [31:0] busA,
  output logic [31:0] pc_out,
  output logic [31:0] link_addr,
  output logic        addr_err,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] p4;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        next_misaligned;
  logic        unused_jumplink;

  // jal only matters downstream through link_addr, which is always pc+4
  assign unused_jumplink = jumplink;

  assign p4        = pc_out + 32'd4;
  assign link_addr = p4;
  assign imem_addr = pc_out;
  assign br_off    = {{14{Instruction[15]}}, Instruction[15:0], 2'b00};

  always_comb begin
    next_pc = p4;
    if (jumpreg)
      next_pc = busA;
    else if (jump)
      next_pc = {p4[31:28], Instruction[25:0], 2'b00};
    else if (branch && zero)
      next_pc = p4 + br_off;
  end

  assign next_misaligned = (next_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_RST;
    else
      state <= state_nxt;
  end

  // Outputs decode from the state register, so an async reset drops imem_req at once
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_RST: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)
          state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (instr_accept)
          state_nxt = next_misaligned ? S_ERROR : S_FETCH;
      end
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out      <= RESET_PC;
      Instruction <= 32'd0;
      addr_err    <= 1'b0;
      retire_cnt  <= 32'd0;
    end else begin
      if (state == S_FETCH && imem_ack)
        Instruction <= imem_rdata;
      if (state == S_ISSUE && instr_accept) begin
        retire_cnt <= retire_cnt + 32'd1;
        if (next_misaligned)
          addr_err <= 1'b1;
        else
          pc_out <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: fetch stimulus pushes expected {pc, instruction},
// a negedge monitor pops and compares whenever a new instruction is presented.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic        instr_accept;
  logic        branch, jump, jumpreg, jumplink, zero;
  logic [31:0] busA;
  logic [31:0] pc_out;
  logic [31:0] link_addr;
  logic        addr_err;
  logic [31:0] retire_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic cur_ok = 1'b0;
  logic vld_d  = 1'b0;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instruction(Instruction), .instr_valid(instr_valid), .instr_accept(instr_accept),
    .branch(branch), .jump(jump), .jumpreg(jumpreg), .jumplink(jumplink), .zero(zero),
    .busA(busA), .pc_out(pc_out), .link_addr(link_addr), .addr_err(addr_err),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: new instruction presented -> pop expected; every ISSUE cycle -> Instruction held
  always @(negedge clk) begin
    if (rst_n && instr_valid) begin
      if (!vld_d) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got pc %h with empty queue", pc_out);
          cur_ok = 1'b0;
        end else begin
          cur    = exp_q.pop_front();
          cur_ok = 1'b1;
          chk("sb_pc", pc_out, cur.pc);
        end
      end
      if (cur_ok) chk("sb_instr", Instruction, cur.instr);
    end
    vld_d = rst_n && instr_valid;
  end

  task automatic wait_req();
    for (int i = 0; i < 50 && !imem_req; i++) @(negedge clk);
    chk("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge where the DUT is in ISSUE
  task automatic fetch(input logic [31:0] pc, input logic [31:0] w, input int waits);
    wait_req();
    chk("imem_addr", imem_addr, pc);
    repeat (waits) @(negedge clk);
    chk("addr_hold", imem_addr, pc);
    exp_q.push_back({pc, w});
    imem_ack   = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("issue_req_low", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic retire(input int dly, input logic b, input logic j, input logic jr,
                        input logic jl, input logic z, input logic [31:0] a);
    for (int i = 0; i < 50 && !instr_valid; i++) @(negedge clk);
    chk("valid_seen", {31'd0, instr_valid}, 32'd1);
    repeat (dly) @(negedge clk);
    branch = b; jump = j; jumpreg = jr; jumplink = jl; zero = z; busA = a;
    instr_accept = 1'b1;
    @(negedge clk);
    instr_accept = 1'b0;
    branch = 1'b0; jump = 1'b0; jumpreg = 1'b0; jumplink = 1'b0; zero = 1'b0;
    busA = 32'h5555_5555;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    instr_accept = 1'b0; branch = 1'b0; jump = 1'b0; jumpreg = 1'b0;
    jumplink = 1'b0; zero = 1'b0; busA = 32'd0;

    // 1. reset with ack present
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    rst_n = 1'b1; imem_ack = 1'b0;
    @(negedge clk);
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'd0);

    // 2. sequential fetch
    fetch(32'h0, 32'h2008_0001, 3);
    retire(2, 0, 0, 0, 0, 0, 32'd0);
    chk("seq_pc1", pc_out, 32'h4);
    fetch(32'h4, 32'h2009_0002, 3);
    retire(2, 0, 0, 0, 0, 0, 32'd0);
    chk("seq_pc2", pc_out, 32'h8);
    chk("seq_cnt", retire_cnt, 32'd2);

    // 3. beq taken (0x10 -> 0x0C) and not taken (0x10 -> 0x14)
    fetch(32'h8, 32'h0000_0020, 0);
    retire(0, 0, 0, 0, 0, 0, 32'd0);
    fetch(32'hC, 32'h0000_0020, 0);
    retire(0, 0, 0, 0, 0, 0, 32'd0);
    chk("pre_beq_pc", pc_out, 32'h10);
    fetch(32'h10, 32'h1000_FFFE, 1);
    retire(1, 1, 0, 0, 0, 1, 32'd0);
    chk("beq_taken", pc_out, 32'hC);
    fetch(32'hC, 32'h0000_0020, 0);
    retire(0, 0, 0, 0, 0, 0, 32'd0);
    fetch(32'h10, 32'h1000_FFFE, 0);
    retire(0, 1, 0, 0, 0, 0, 32'd0);
    chk("beq_not_taken", pc_out, 32'h14);

    // 4. jr to 0x0040_0020, then jal
    fetch(32'h14, 32'h03E0_0008, 0);
    retire(0, 0, 0, 1, 0, 0, 32'h0040_0020);
    chk("jr_pc", pc_out, 32'h0040_0020);
    fetch(32'h0040_0020, 32'h0C10_0010, 2);
    chk("jal_link", link_addr, 32'h0040_0024);
    retire(1, 0, 1, 0, 1, 0, 32'd0);
    chk("jal_pc", pc_out, 32'h0040_0040);

    // 5. jr beats j (and branch), then misaligned jr target
    fetch(32'h0040_0040, 32'h0800_0000, 0);
    retire(0, 1, 1, 1, 0, 1, 32'h0000_0100);
    chk("jr_prio_pc", pc_out, 32'h100);
    fetch(32'h100, 32'h0800_0000, 0);
    retire(0, 0, 1, 1, 0, 0, 32'h0000_0102);
    chk("err_flag", {31'd0, addr_err}, 32'd1);
    chk("err_pc_hold", pc_out, 32'h100);
    chk("err_cnt", retire_cnt, 32'd11);
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_req", {31'd0, imem_req}, 32'd0);
    chk("err_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("err_clr", {31'd0, addr_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6. reset mid-fetch, late ack ignored
    fetch(32'h0, 32'h2008_0003, 0);
    retire(0, 0, 0, 0, 0, 0, 32'd0);
    wait_req();
    chk("mid_addr", imem_addr, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_req", {31'd0, imem_req}, 32'd0);
    chk("mid_pc", pc_out, 32'h0);
    chk("mid_cnt", retire_cnt, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_ack_req", {31'd0, imem_req}, 32'd1);
    chk("late_ack_instr", Instruction, 32'd0);
    fetch(32'h0, 32'h2008_0004, 1);
    retire(0, 0, 0, 0, 0, 0, 32'd0);
    chk("post_pc", pc_out, 32'h4);
    chk("post_cnt", retire_cnt, 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch and next-PC stage that sits directly upstream of the instruction decoder and control unit. It holds the PC and fetches words from instruction memory over a req/ack handshake. It presents the fetched Instruction to the decoder. When the datapath retires the instruction, it consumes the decoder's jump/branch/jumpreg/jumplink outputs to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word address of fetch; equals pc_out
imem_ack  in  1  memory has returned imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
Instruction  out  32  registered instruction word, driven to the decoder
instr_valid  out  1  Instruction is valid and awaiting retirement
instr_accept  in  1  datapath retires the current instruction this cycle
branch  in  1  decoded beq
jump  in  1  decoded j/jal
jumpreg  in  1  decoded jr
jumplink  in  1  decoded jal
zero  in  1  ALU zero flag for the current instruction
busA  in  32  rs register value, the jr target
pc_out  out  32  current PC
link_addr  out  32  pc_out+4; written to $31 by jal
addr_err  out  1  sticky misaligned-jump-target error
retire_cnt  out  32  retired-instruction counter

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: pc_out=RESET_PC, Instruction=0, instr_valid=0, imem_req=0, addr_err=0, retire_cnt=0, state=RST.
- States: RST, FETCH, ISSUE, ERROR.
- RST: entered only via reset. Moves to FETCH on the first clock edge after rst_n deasserts.
- FETCH:
  - imem_req=1; imem_addr=pc_out, held stable while req is high.
  - Edge with imem_ack=1: Instruction<=imem_rdata, go to ISSUE.
  - imem_ack is ignored in every other state.
- ISSUE:
  - instr_valid=1, imem_req=0.
  - Decoder outputs, zero and busA are sampled only here, on an edge with instr_accept=1.
  - With instr_accept=0: hold everything, for any number of cycles.
- Next-PC selection on the accept edge (p4 = pc_out+4, 32-bit, wraps modulo 2^32):
  - jumpreg=1: busA.
  - else jump=1: {p4[31:28], Instruction[25:0], 2'b00}.
  - else branch=1 and zero=1: p4 + (sign_extend(Instruction[15:0]) << 2), modulo 2^32.
  - else: p4.
  - Priority is fixed in this order even if several inputs are high at once.
  - jumplink does not alter selection. It only qualifies link_addr, which is combinationally pc_out+4 at all times.
- Accept edge, normal case: pc_out<=next PC, retire_cnt<=retire_cnt+1 (wraps to 0 after 2^32-1), go to FETCH.
- Accept edge, next PC has [1:0]!=0: addr_err<=1, pc_out unchanged, retire_cnt still increments, go to ERROR.
- ERROR: imem_req=0, instr_valid=0. Held until reset.
- Latency: minimum 2 cycles per instruction (ack in the first FETCH cycle, accept in the first ISSUE cycle).
- Reset mid-operation: takes effect immediately, without waiting for a clock edge.
  - imem_req drops at once, even during an outstanding fetch.
  - A late imem_ack after reset is ignored until FETCH is re-entered.
- pc_out, Instruction and instr_valid are registered outputs. imem_addr and link_addr are combinational from pc_out.

Test Plan:
1. Reset: hold rst_n=0 with an ack pulse present -> imem_req=0, instr_valid=0, pc_out=0. Release -> imem_req=1, imem_addr=0 on the next cycle.
2. Sequential fetch: ack after 3 wait cycles, accept 2 cycles after instr_valid, no control inputs -> pc_out 0 -> 4 -> 8. retire_cnt=2 after two retirements. Instruction stable throughout ISSUE.
3. beq: pc_out=0x10, Instruction[15:0]=0xFFFE.
   - branch=1, zero=1 -> next pc_out=0x0C.
   - branch=1, zero=0 -> next pc_out=0x14.
4. jal: pc_out=0x0040_0020, Instruction=0x0C10_0010, jump=1, jumplink=1 -> link_addr=0x0040_0024 during ISSUE; next pc_out=0x0040_0040.
5. jr priority and error:
   - jumpreg=1, jump=1, busA=0x100 -> next pc_out=0x100.
   - Repeat with busA=0x102 -> addr_err=1, ERROR state, imem_req stays 0; rst_n pulse clears addr_err.
6. Reset mid-fetch: assert rst_n=0 while imem_req=1 before ack -> imem_req falls asynchronously, pc_out=RESET_PC, retire_cnt=0.
